boruss_fetch_unit: RTL
======================

Name: boruss_fetch_unit

Overview:
- Instruction prefetch stage between the memory controller's instruction port and the CPU FSM.
- Issues sequential ROM reads and buffers returned bytes in a small FIFO, tagging each byte with its address.
- Presents bytes to the FSM over a valid/ready handshake.
- A jump redirect from the FSM flushes the queue, discards any in-flight byte and restarts fetch at the target.

Parameters:
- DEPTH, 4, prefetch FIFO entries; power of two, 2..16.
- RESET_PC, 8'h00, first fetch address after reset.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- rom_addr  output  8  instruction address to memory controller
- rom_req  output  1  read request; data returns exactly 1 cycle later
- rom_data  input  8  instruction byte, valid the cycle after rom_req
- instr_valid  output  1  head of FIFO holds a valid byte
- instr_data  output  8  head byte
- instr_pc  output  8  address of head byte
- instr_ready  input  1  FSM consumes head when instr_valid & instr_ready
- jump_valid  input  1  redirect request, single-cycle pulse
- jump_target  input  8  redirect address
- fetch_busy  output  1  high in REDIRECT state or while a request is in flight

Behaviour:
- Reset, sampled on posedge clk only:
  - fetch_pc = RESET_PC; FIFO empty; inflight = 0; state = RUN.
  - Outputs: rom_req = 0, rom_addr = RESET_PC, instr_valid = 0, instr_data = 0, instr_pc = 0, fetch_busy = 0.
- Reset mid-operation discards everything, including an in-flight response. The byte returned in the cycle after reset deasserts is ignored.
- States:
  - RUN: normal fetch.
  - REDIRECT: one cycle; FIFO empty, no request issued, fetch_pc already holds the target.
  - RUN -> REDIRECT on jump_valid.
  - REDIRECT -> RUN unconditionally.
  - jump_valid while in REDIRECT reloads the target and stays in REDIRECT one more cycle.
- Issue rule (combinational): rom_req = (state == RUN) & ~jump_valid & (count + inflight + pending_push < DEPTH). In words, reserve a slot for every outstanding byte.
- Issue timing:
  - rom_addr = fetch_pc at all times.
  - On issue, fetch_pc <= fetch_pc + 1, modulo 256 (8'hFF wraps to 8'h00).
  - inflight <= 1, and the issued address is latched as inflight_pc.
- Response: the cycle after an issue, rom_data is pushed with inflight_pc, unless a redirect occurred on the issue cycle or the response cycle.
- Sustained throughput is 1 byte/cycle when the FSM accepts every cycle. First byte after reset or redirect appears at instr_valid 2 cycles after the request cycle.
- Simultaneous push and pop: the count is unchanged and both take effect, including when the FIFO is full (DEPTH) at the start of the cycle.
- Pop on empty: no effect. instr_data/instr_pc hold their last values while instr_valid = 0.
- Redirect priority (jump_valid = 1):
  - Clears the FIFO (count = 0) and suppresses the same-cycle pop and push.
  - Drops the in-flight byte.
  - Sets fetch_pc <= jump_target.
  - instr_valid = 0 from the next cycle.
- Full: rom_req = 0 and fetch_pc holds. No byte is ever lost or duplicated.
- Pointers: log2(DEPTH)-bit read/write pointers wrap naturally; count is log2(DEPTH)+1 bits.

Optional Feature:
- Macro: BORUSS_FETCH_STATS_EN.
- Defined: adds output ports stat_fetched[15:0] (pushes committed into the FIFO) and stat_flushed[15:0] (entries plus in-flight bytes discarded by redirects).
  - Both counters are cleared by reset.
  - Both saturate at 16'hFFFF.
- Undefined: those ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset release, instr_ready = 1, ROM[i] = i+8'h10 -> rom_req high cycle 0 at 8'h00. First instr_valid on cycle 2 with data 8'h10, pc 8'h00. Then one byte per cycle: 8'h11, 8'h12, ...
- instr_ready = 0 held -> exactly DEPTH = 4 entries queued, rom_req low, rom_addr 8'h04. Assert ready -> bytes at pc 00..03 drain in order, then fetch resumes at 8'h04 with no gap beyond the 1-cycle latency.
- jump_valid with target 8'h40, while the FIFO holds 3 entries and 1 byte is in flight -> next cycle instr_valid = 0. Next request at 8'h40; first valid byte has pc 8'h40. With stats enabled, stat_flushed += 4.
- RESET_PC = 8'hFE, ready = 1 -> instr_pc sequence FE, FF, 00, 01.
- Reset asserted one cycle after a request -> the returned byte is never presented; first valid byte after reset is pc RESET_PC.
- Back-to-back jump_valid to 8'h20 then 8'h30 -> no byte from 8'h20 is ever presented; the first presented pc is 8'h30.

Source files
------------

// File: rtl/boruss_fetch_unit.sv
// ---------------------------------------------------------------------------
// boruss_fetch_unit
// Instruction prefetch stage. Issues sequential ROM reads, buffers the
// returned bytes (tagged with their address) in a small FIFO and hands them
// to the CPU FSM over a valid/ready handshake. A jump redirect flushes the
// queue, drops any in-flight byte and restarts fetch at the target.
//
// Optional build macro: BORUSS_FETCH_STATS_EN
//   Adds stat_fetched_o / stat_flushed_o saturating counters.
//
// Ports:
//   clk_i           system clock
//   reset_i         synchronous, active-high reset
//   rom_addr_o      instruction address to memory controller (= fetch_pc)
//   rom_req_o       read request; data returns one cycle later
//   rom_data_i      instruction byte, valid the cycle after rom_req_o
//   instr_valid_o   FIFO head holds a valid byte
//   instr_data_o    head byte (holds last value while not valid)
//   instr_pc_o      address of head byte (holds last value while not valid)
//   instr_ready_i   FSM consumes the head when valid & ready
//   jump_valid_i    redirect request, single-cycle pulse
//   jump_target_i   redirect address
//   fetch_busy_o    REDIRECT state or a request in flight
//   stat_fetched_o  (stats build) pushes committed into the FIFO
//   stat_flushed_o  (stats build) entries + in-flight bytes discarded
//
// State table:
//   ST_RUN      | normal sequential fetch
//   ST_REDIRECT | one-cycle bubble after a jump; FIFO empty, no request
// ---------------------------------------------------------------------------
module boruss_fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [7:0]  RESET_PC = 8'h00
) (
    input  logic        clk_i,
    input  logic        reset_i,
    output logic [7:0]  rom_addr_o,
    output logic        rom_req_o,
    input  logic [7:0]  rom_data_i,
    output logic        instr_valid_o,
    output logic [7:0]  instr_data_o,
    output logic [7:0]  instr_pc_o,
    input  logic        instr_ready_i,
    input  logic        jump_valid_i,
    input  logic [7:0]  jump_target_i,
`ifdef BORUSS_FETCH_STATS_EN
    output logic        fetch_busy_o,
    output logic [15:0] stat_fetched_o,
    output logic [15:0] stat_flushed_o
`else
    output logic        fetch_busy_o
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    typedef enum logic {
        ST_RUN,
        ST_REDIRECT
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      fetch_pc_q, fetch_pc_d;
    logic            inflight_q, inflight_d;
    logic [7:0]      inflight_pc_q, inflight_pc_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [15:0]     last_q, last_d;
    logic [15:0]     fifo_q [DEPTH];

    logic            issue;
    logic            push;
    logic            pop;
    logic            head_valid;
    logic [15:0]     head;
    logic [CW:0]     occupancy;

    always_comb begin
        head_valid = (count_q != '0);
        head       = fifo_q[rd_ptr_q];
        // The byte arriving this cycle already owns a slot, so it is
        // counted before another request is allowed.
        occupancy  = {1'b0, count_q} + (CW+1)'(inflight_q);
        issue      = ~reset_i & (state_q == ST_RUN) & ~jump_valid_i &
                     (occupancy < DEPTH_W);
        push       = inflight_q & ~jump_valid_i;
        pop        = head_valid & instr_ready_i & ~jump_valid_i;
    end

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        last_d        = head_valid ? head : last_q;

        if (jump_valid_i) begin
            state_d    = ST_REDIRECT;
            fetch_pc_d = jump_target_i;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            state_d = ST_RUN;
            if (issue) begin
                fetch_pc_d    = fetch_pc_q + 8'd1;
                inflight_d    = 1'b1;
                inflight_pc_d = fetch_pc_q;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= ST_RUN;
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 8'h00;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            last_q        <= 16'h0000;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            last_q        <= last_d;
        end
    end

    // Storage needs no reset: nothing is read unless count_q says it is valid.
    always_ff @(posedge clk_i) begin
        if (push && !reset_i) begin
            fifo_q[wr_ptr_q] <= {inflight_pc_q, rom_data_i};
        end
    end

    assign rom_addr_o    = fetch_pc_q;
    assign rom_req_o     = issue;
    assign instr_valid_o = head_valid;
    assign instr_pc_o    = head_valid ? head[15:8] : last_q[15:8];
    assign instr_data_o  = head_valid ? head[7:0]  : last_q[7:0];
    assign fetch_busy_o  = (state_q == ST_REDIRECT) | inflight_q;

`ifdef BORUSS_FETCH_STATS_EN
    logic [15:0] stat_fetched_q;
    logic [15:0] stat_flushed_q;
    logic [16:0] flushed_sum;

    always_comb begin
        flushed_sum = {1'b0, stat_flushed_q} + 17'(count_q) + 17'(inflight_q);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stat_fetched_q <= 16'h0000;
            stat_flushed_q <= 16'h0000;
        end else begin
            if (push && stat_fetched_q != 16'hFFFF) begin
                stat_fetched_q <= stat_fetched_q + 16'd1;
            end
            if (jump_valid_i) begin
                stat_flushed_q <= flushed_sum[16] ? 16'hFFFF : flushed_sum[15:0];
            end
        end
    end

    assign stat_fetched_o = stat_fetched_q;
    assign stat_flushed_o = stat_flushed_q;
`endif

endmodule
